// File: rtl/lsu.sv
// Load/store unit: single-outstanding master of the byte-addressed data memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module lsu #(
  parameter int unsigned MEM_BYTES = 1376
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwr,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AddrW = 32;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t           state_q;
  logic             we_q;
  logic             signed_q;
  logic [1:0]       size_q;
  logic [AddrW-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             rsp_valid_q;
  logic             rsp_fault_q;
  logic [31:0]      rsp_rdata_q;
  logic [AddrW-1:0] mem_raddr_q;
  logic [AddrW-1:0] mem_waddr_q;
  logic [31:0]      mem_wdata_q;
  logic             mem_memwr_q;

  logic             fault_c;
  logic [31:0]      load_c;
  logic [31:0]      merge_c;

  // Acceptance-time rejection; the memory always touches 4 bytes, so bound on addr+4.
  always_comb begin
    fault_c = (req_size == 2'b11) ||
              (({1'b0, req_addr} + 33'd4) > 33'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == 2'b01) && req_addr[0])
      fault_c = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
      fault_c = 1'b1;
`endif
  end

  always_comb begin
    case (size_q)
      2'b00:   load_c = {{24{signed_q & mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   load_c = {{16{signed_q & mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_c = mem_rdata;
    endcase
    if (size_q == 2'b00)
      merge_c = {mem_rdata[31:8], wdata_q[7:0]};
    else
      merge_c = {mem_rdata[31:16], wdata_q[15:0]};
  end

  // Request sequencer; memory-side outputs hold outside RD/WR except the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_memwr_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      mem_memwr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (fault_c) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (req_we && (req_size == 2'b10)) begin
              state_q     <= WR;
              mem_memwr_q <= 1'b1;
              mem_waddr_q <= req_addr;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q     <= RD;
              mem_raddr_q <= req_addr;
            end
          end
        end
        RD: begin
          if (we_q) begin
            state_q     <= WR;
            mem_memwr_q <= 1'b1;
            mem_waddr_q <= addr_q;
            mem_wdata_q <= merge_c;
          end else begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_c;
          end
        end
        WR: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_raddr = mem_raddr_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_memwr = mem_memwr_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a falling-edge byte memory model.
module tb_lsu;

  localparam int unsigned MEM = 1376;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_memwr;
  logic [31:0] mem_rdata = 32'h0;

  bit [7:0] mem [0:MEM-1];
  int wr_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  lsu #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_memwr(mem_memwr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [10:0] i;
    i = 11'(a);
    return {mem[i+11'd3], mem[i+11'd2], mem[i+11'd1], mem[i]};
  endfunction

  // Memory acts at the falling edge: 4-byte write and 4-byte little-endian read.
  always @(negedge clk) begin
    if (mem_memwr) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_waddr <= 32'(MEM - 4))
        for (int k = 0; k < 4; k++)
          mem[11'(mem_waddr) + 11'(k)] <= mem_wdata[8*k +: 8];
    end
    if (mem_raddr <= 32'(MEM - 4))
      mem_rdata <= mword(mem_raddr);
    else
      mem_rdata <= 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, scramble inputs after acceptance, wait for the response.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic flt);
    chk({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
    req_addr = 32'h0000_0004; req_wdata = 32'h5A5A_5A5A;
    chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    flt = rsp_fault;
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        flt;
  int          wc;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_memwr", 32'(mem_memwr), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_raddr", mem_raddr, 32'h0);
    chk("rst_waddr", mem_waddr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Word store then word load.
    do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, flt);
    chk("sw10_lat", 32'(lat), 32'd1);
    chk("sw10_fault", 32'(flt), 32'd0);
    chk("sw10_rdata", rd, 32'h0);
    chk("sw10_wrcnt", 32'(wr_cnt), 32'd1);
    chk("sw10_mem", mword(32'h10), 32'hDEAD_BEEF);
    do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, flt);
    chk("lw10_lat", 32'(lat), 32'd1);
    chk("lw10_rdata", rd, 32'hDEAD_BEEF);
    chk("lw10_wrcnt", 32'(wr_cnt), 32'd1);

    // Byte store read-modify-write and signed/unsigned byte loads.
    do_req("sb11", 1'b1, 2'b00, 1'b1, 32'h11, 32'h1234_5680, lat, rd, flt);
    chk("sb11_lat", 32'(lat), 32'd2);
    chk("sb11_wrcnt", 32'(wr_cnt), 32'd2);
    chk("sb11_mem", mword(32'h10), 32'hDEAD_80EF);
    do_req("lbs11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, flt);
    chk("lbs11_rdata", rd, 32'hFFFF_FF80);
    do_req("lbu11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, flt);
    chk("lbu11_rdata", rd, 32'h0000_0080);

    // Half store over a preset word.
    do_req("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA_AAAA, lat, rd, flt);
    do_req("sh20", 1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF_1234, lat, rd, flt);
    chk("sh20_lat", 32'(lat), 32'd2);
    chk("sh20_fault", 32'(flt), 32'd0);
    chk("sh20_mem", mword(32'h20), 32'hAAAA_1234);
    do_req("lhs20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, rd, flt);
    chk("lhs20_rdata", rd, 32'h0000_1234);

    // Misaligned half load: bytes 0x21=0x12, 0x22=0xAA.
    do_req("lhs21", 1'b0, 2'b01, 1'b1, 32'h21, 32'h0, lat, rd, flt);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lhs21_fault", 32'(flt), 32'd1);
    chk("lhs21_rdata", rd, 32'h0);
`else
    chk("lhs21_fault", 32'(flt), 32'd0);
    chk("lhs21_rdata", rd, 32'hFFFF_AA12);
`endif
    do_req("lhu21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat, rd, flt);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lhu21_fault", 32'(flt), 32'd1);
`else
    chk("lhu21_rdata", rd, 32'h0000_AA12);
`endif

    // Bounds and reserved-size faults.
    wc = wr_cnt;
    do_req("lb1373", 1'b0, 2'b00, 1'b0, 32'd1373, 32'h0, lat, rd, flt);
    chk("lb1373_fault", 32'(flt), 32'd1);
    chk("lb1373_lat", 32'(lat), 32'd0);
    chk("lb1373_rdata", rd, 32'h0);
    do_req("lw1372", 1'b0, 2'b10, 1'b0, 32'd1372, 32'h0, lat, rd, flt);
    chk("lw1372_fault", 32'(flt), 32'd0);
    chk("lw1372_lat", 32'(lat), 32'd1);
    chk("lw1372_rdata", rd, 32'h0);
    do_req("sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, flt);
    chk("sz11_fault", 32'(flt), 32'd1);
    do_req("sw_oob", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h1111_1111, lat, rd, flt);
    chk("sw_oob_fault", 32'(flt), 32'd1);
    chk("sw_oob_lat", 32'(lat), 32'd0);
    chk("fault_wrcnt", 32'(wr_cnt), 32'(wc));

    // Reset during RD of a sub-word store drops it without a write.
    wc = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rrd_memwr_rd", 32'(mem_memwr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rrd_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rrd_memwr", 32'(mem_memwr), 32'd0);
    chk("rrd_ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rrd_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rrd_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("rrd_wrcnt", 32'(wr_cnt), 32'(wc));
    chk("rrd_mem", mword(32'h30), 32'h0);

    // Unit still usable after the dropped request.
    do_req("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, flt);
    chk("lw10b_rdata", rd, 32'hDEAD_80EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
